// File: rtl/amp_mod_multi.sv
// Multi-channel amplitude modulator: bypass, ring, unipolar AM, rectified ring.
// Three-stage valid/ready pipeline with round-half-up and output saturation.
module amp_mod_multi #(
   parameter  int DATA_WIDTH = 16,
   parameter  int NUM_CH     = 4,
   localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [CW-1:0]         ch_i,
   input  logic [DATA_WIDTH-1:0] signal_i,
   input  logic [DATA_WIDTH-1:0] modulator_i,
   input  logic                  cfg_we_i,
   input  logic [CW-1:0]         cfg_ch_i,
   input  logic [1:0]            cfg_mode_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [CW-1:0]         ch_o,
   output logic [DATA_WIDTH-1:0] signal_o,
   output logic                  sat_o
);

   localparam int W  = DATA_WIDTH;
   localparam int PW = 2 * W + 1;

   typedef enum logic [1:0] {
      MD_BYP  = 2'd0,
      MD_RING = 2'd1,
      MD_AM   = 2'd2,
      MD_RECT = 2'd3
   } mode_e;

   localparam logic signed [PW-1:0] MAXV =
      {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [PW-1:0] MINV =
      {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};
   localparam logic signed [PW-1:0] RND =
      {{(PW-W+1){1'b0}}, 1'b1, {(W-2){1'b0}}};

   mode_e                 mode_q [NUM_CH];

   logic                  v1_q;
   logic [CW-1:0]         ch1_q;
   logic signed [W-1:0]   s1_q;
   logic signed [W-1:0]   m1_q;
   mode_e                 md1_q;

   logic                  v2_q;
   logic [CW-1:0]         ch2_q;
   logic signed [W-1:0]   s2_q;
   logic signed [PW-1:0]  p2_q;
   mode_e                 md2_q;

   logic                  valid_q;
   logic [CW-1:0]         ch_q;
   logic [W-1:0]          sig_q;
   logic                  sat_q;

   logic                  en;
   logic signed [PW-1:0]  s_x;
   logic signed [PW-1:0]  m_x;
   logic signed [PW-1:0]  g_x;
   logic [W-1:0]          g_u;
   logic signed [PW-1:0]  ring;
   logic signed [PW-1:0]  am;
   logic signed [PW-1:0]  p_d;
   logic signed [PW-1:0]  rnd;
   logic signed [PW-1:0]  r;
   logic [W-1:0]          sig_d;
   logic                  sat_d;

   // Whole pipeline moves as one; a bubble only collapses if the output drains.
   assign en      = ready_i | ~valid_q;
   assign ready_o = en;

   assign valid_o  = valid_q;
   assign ch_o     = ch_q;
   assign signal_o = sig_q;
   assign sat_o    = sat_q;

   always_comb begin
      s_x  = PW'(s1_q);
      m_x  = PW'(m1_q);
      // Flipping the sign bit gives m + H as an unsigned value.
      g_u  = {~m1_q[W-1], m1_q[W-2:0]} >> 1;
      g_x  = {{(PW-W){1'b0}}, g_u};
      ring = s_x * m_x;
      am   = s_x * g_x;
      p_d  = '0;
      unique case (1'b1)
         (md1_q == MD_BYP):  p_d = '0;
         (md1_q == MD_RING): p_d = ring;
         (md1_q == MD_AM):   p_d = am;
         (md1_q == MD_RECT): p_d = ring[PW-1] ? -ring : ring;
         default:            p_d = '0;
      endcase
   end

   always_comb begin
      rnd   = p2_q + RND;
      r     = rnd >>> (W - 1);
      sig_d = r[W-1:0];
      sat_d = 1'b0;
      unique case (1'b1)
         (md2_q == MD_BYP): begin
            sig_d = s2_q;
            sat_d = 1'b0;
         end
         (r > MAXV): begin
            sig_d = {1'b0, {(W-1){1'b1}}};
            sat_d = 1'b1;
         end
         (r < MINV): begin
            sig_d = {1'b1, {(W-1){1'b0}}};
            sat_d = 1'b1;
         end
         default: begin
            sig_d = r[W-1:0];
            sat_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_CH; i++) begin
            mode_q[i] <= MD_BYP;
         end
         v1_q    <= 1'b0;
         ch1_q   <= '0;
         s1_q    <= '0;
         m1_q    <= '0;
         md1_q   <= MD_BYP;
         v2_q    <= 1'b0;
         ch2_q   <= '0;
         s2_q    <= '0;
         p2_q    <= '0;
         md2_q   <= MD_BYP;
         valid_q <= 1'b0;
         ch_q    <= '0;
         sig_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         if (cfg_we_i) begin
            mode_q[cfg_ch_i] <= mode_e'(cfg_mode_i);
         end
         if (en) begin
            v1_q <= valid_i;
            if (valid_i) begin
               ch1_q <= ch_i;
               s1_q  <= signal_i;
               m1_q  <= modulator_i;
               md1_q <= mode_q[ch_i];
            end
            v2_q <= v1_q;
            if (v1_q) begin
               ch2_q <= ch1_q;
               s2_q  <= s1_q;
               p2_q  <= p_d;
               md2_q <= md1_q;
            end
            valid_q <= v2_q;
            if (v2_q) begin
               ch_q  <= ch2_q;
               sig_q <= sig_d;
               sat_q <= sat_d;
            end
         end
      end
   end

endmodule
